ram_read_stream: RTL and testbench

//  Valid/ready front end for the read port of RawRAM/RawROM, which has a fixed

---
 rtl/ram_read_stream_if.sv | 27 ++
 rtl/ram_read_stream.sv | 141 ++++++++++++++
 tb/tb_ram_read_stream.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_read_stream_if.sv
// Request, memory read port and response signals of ram_read_stream.
// The slave modport is the stream block. The master modport is whatever drives
// the requests, models the memory and consumes the responses.
interface ram_read_stream_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             ram_read;
    logic [AW-1:0]    ram_addrb;
    logic [WIDTH-1:0] ram_doutb;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;

    modport slave (
        input  req_valid, req_addr, ram_doutb, resp_ready,
        output req_ready, ram_read, ram_addrb, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_addr, ram_doutb, resp_ready,
        input  req_ready, ram_read, ram_addrb, resp_valid, resp_data
    );
endinterface

// File: rtl/ram_read_stream.sv
// ram_read_stream: valid/ready front end for a fixed-latency memory read port.
// Each accepted request takes one credit. The credit comes back when its word
// leaves the response FIFO. Because of this, a word returned by the memory
// always finds a free FIFO slot, and the memory needs no backpressure.

// Invariant checker for the response FIFO.
module ram_read_stream_chk #(
    parameter int BUF_DEPTH = 4,
    parameter int OW        = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [OW-1:0] cnt,
    input logic [OW-1:0] occ
);
    a_cnt_bound:    assert property (@(posedge clk) disable iff (rst) cnt <= OW'(BUF_DEPTH));
    a_occ_bound:    assert property (@(posedge clk) disable iff (rst) occ <= OW'(BUF_DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && (cnt == OW'(BUF_DEPTH))));
endmodule

module ram_read_stream #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 2,
    parameter int BUF_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_read_stream_if.slave  bus
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [OW-1:0] OCC_MAX  = OW'(BUF_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

    logic [OW-1:0]           occ_r;
    logic [READ_LATENCY-1:0] vpipe_r;
    logic [WIDTH-1:0]        buf_r [BUF_DEPTH];
    logic [PW-1:0]           rd_ptr_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [OW-1:0]           cnt_r;

    logic req_ready_s;
    logic accept_s;
    logic resp_valid_s;
    logic pop_s;
    logic push_s;

    // Pointer increment with an explicit wrap, so that BUF_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // req_ready comes only from registered state and the reset.
    assign req_ready_s  = !rst && (occ_r < OCC_MAX);
    assign accept_s     = bus.req_valid && req_ready_s;
    assign resp_valid_s = !rst && (cnt_r != {OW{1'b0}});
    assign pop_s        = resp_valid_s && bus.resp_ready;
    assign push_s       = vpipe_r[READ_LATENCY-1];

    assign bus.req_ready  = req_ready_s;
    assign bus.ram_read   = accept_s;
    assign bus.ram_addrb  = bus.req_addr;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_data  = buf_r[rd_ptr_r];

    // Credit counter: in-flight reads plus buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= {OW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Valid pipe that tracks each issued read until its data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_r <= {READ_LATENCY{1'b0}};
        end else begin
            vpipe_r[0] <= accept_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
        end
    end

    // FIFO storage: capture the returned memory word at the tail.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            buf_r[wr_ptr_r] <= bus.ram_doutb;
        end else begin
            buf_r[wr_ptr_r] <= buf_r[wr_ptr_r];
        end
    end

    // FIFO pointers and word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            cnt_r    <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + OW'(1);
                2'b01:   cnt_r <= cnt_r - OW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    ram_read_stream_chk #(
        .BUF_DEPTH (BUF_DEPTH),
        .OW        (OW)
    ) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .cnt  (cnt_r),
        .occ  (occ_r)
    );
endmodule

// File: tb/tb_ram_read_stream.sv
// Testbench for ram_read_stream. There are two instances: BUF_DEPTH 4 and BUF_DEPTH 3.
// A memory model returns mem[addr] READ_LATENCY cycles after an address is presented.
// Each cycle a reference model checks every instance:
//   - expected-word queue: filled on accept, emptied on response;
//   - credit count: accepts minus pops.
module tb_ram_read_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RL    = 2;
    localparam int BD0   = 4;
    localparam int BD1   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_read_stream_if #(.WIDTH(WIDTH), .AW(AW)) b0 ();
    ram_read_stream_if #(.WIDTH(WIDTH), .AW(AW)) b1 ();

    ram_read_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_LATENCY(RL), .BUF_DEPTH(BD0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    ram_read_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_LATENCY(RL), .BUF_DEPTH(BD1))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ap0 [RL];
    logic [AW-1:0]    ap1 [RL];

    // Memory model: the address seen in cycle t selects the data for cycle t+RL.
    always @(posedge clk) begin
        ap0[0] <= b0.ram_addrb;
        ap1[0] <= b1.ram_addrb;
        for (int i = 1; i < RL; i++) begin
            ap0[i] <= ap0[i-1];
            ap1[i] <= ap1[i-1];
        end
    end
    assign b0.ram_doutb = mem[ap0[RL-1]];
    assign b1.ram_doutb = mem[ap1[RL-1]];

    int total  = 0;
    int passed = 0;
    int occ0 = 0;
    int occ1 = 0;
    int nresp1 = 0;
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    int na;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for instance 0.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready0", 32'(b0.req_ready), 32'd0);
            chk("rst_ram_read0", 32'(b0.ram_read), 32'd0);
            chk("rst_resp_valid0", 32'(b0.resp_valid), 32'd0);
            q0.delete();
            occ0 = 0;
        end else begin
            chk("req_ready0", 32'(b0.req_ready), 32'(occ0 < BD0));
            chk("ram_read0", 32'(b0.ram_read), 32'(b0.req_valid && (occ0 < BD0)));
            if (b0.ram_read) chk("ram_addrb0", 32'(b0.ram_addrb), 32'(b0.req_addr));
            if (q0.size() == 0) chk("resp_valid_empty0", 32'(b0.resp_valid), 32'd0);
            if (b0.resp_valid && b0.resp_ready && q0.size() != 0) begin
                chk("resp_data0", 32'(b0.resp_data), 32'(q0.pop_front()));
                occ0--;
            end
            if (b0.req_valid && b0.req_ready) begin
                q0.push_back(mem[b0.req_addr]);
                occ0++;
            end
        end
    end

    // Reference model for instance 1.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready1", 32'(b1.req_ready), 32'd0);
            chk("rst_resp_valid1", 32'(b1.resp_valid), 32'd0);
            q1.delete();
            occ1 = 0;
        end else begin
            chk("req_ready1", 32'(b1.req_ready), 32'(occ1 < BD1));
            if (q1.size() == 0) chk("resp_valid_empty1", 32'(b1.resp_valid), 32'd0);
            if (b1.resp_valid && b1.resp_ready && q1.size() != 0) begin
                chk("resp_data1", 32'(b1.resp_data), 32'(q1.pop_front()));
                occ1--;
                nresp1++;
            end
            if (b1.req_valid && b1.req_ready) begin
                q1.push_back(mem[b1.req_addr]);
                occ1++;
            end
        end
    end

    // One read of address 5 with resp_ready held high. The word is visible only in cycle 3.
    task automatic single_read();
        b0.resp_ready = 1'b1;
        b0.req_valid  = 1'b1;
        b0.req_addr   = AW'(5);
        @(negedge clk);
        chk("t1_ram_read", 32'(b0.ram_read), 32'd1);
        chk("t1_ram_addrb", 32'(b0.ram_addrb), 32'd5);
        step();
        b0.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t1_resp_valid", 32'(b0.resp_valid), 32'(c == 3));
            if (c == 3) chk("t1_resp_data", 32'(b0.resp_data), 32'h0000_00a5);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(0, 255));
        mem[5] = 8'ha5;
        rst = 1'b1;
        b0.req_valid = 1'b1; b0.req_addr = AW'(7); b0.resp_ready = 1'b1;
        b1.req_valid = 1'b0; b1.req_addr = AW'(0); b1.resp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        b0.req_valid = 1'b0;

        // Test 1: single read.
        single_read();

        // Test 2: 16 back-to-back reads.
        for (int c = 0; c < 22; c++) begin
            b0.req_valid = (c < 16);
            b0.req_addr  = AW'(c);
            @(negedge clk);
            if (c < 16) chk("t2_req_ready", 32'(b0.req_ready), 32'd1);
            chk("t2_resp_valid", 32'(b0.resp_valid), 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) chk("t2_resp_data", 32'(b0.resp_data), 32'(mem[c-3]));
            step();
        end
        b0.req_valid = 1'b0;

        // Test 3: backpressure fills the FIFO, then it drains.
        b0.resp_ready = 1'b0;
        b0.req_valid  = 1'b1;
        na = 0;
        for (int c = 0; c < 10; c++) begin
            b0.req_addr = AW'(8 + c);
            @(negedge clk);
            if (b0.req_valid && b0.req_ready) na++;
            step();
        end
        chk("t3_accepts", 32'(na), 32'd4);
        @(negedge clk);
        chk("t3_full_req_ready", 32'(b0.req_ready), 32'd0);
        chk("t3_full_resp_valid", 32'(b0.resp_valid), 32'd1);
        chk("t3_full_resp_data", 32'(b0.resp_data), 32'(mem[8]));
        step();
        b0.resp_ready = 1'b1;
        b0.req_addr   = AW'(20);
        @(negedge clk);
        chk("t3_ready_in_pop_cycle", 32'(b0.req_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t3_ready_after_pop", 32'(b0.req_ready), 32'd1);
        step();
        b0.req_valid = 1'b0;
        repeat (12) step();
        @(negedge clk);
        chk("t3_all_returned", 32'(q0.size()), 32'd0);
        chk("t3_idle_resp_valid", 32'(b0.resp_valid), 32'd0);
        step();

        // Test 4: random valid/ready, 1000 accepted requests.
        na = 0;
        for (int c = 0; c < 20000 && na < 1000; c++) begin
            b0.req_valid  = 1'($urandom_range(0, 1));
            b0.req_addr   = AW'($urandom_range(0, DEPTH - 1));
            b0.resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b0.req_valid && b0.req_ready) na++;
            step();
        end
        chk("t4_accepts", 32'(na), 32'd1000);
        b0.req_valid  = 1'b0;
        b0.resp_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("t4_all_returned", 32'(q0.size()), 32'd0);
        step();

        // Test 5: reset while three reads are in flight.
        for (int c = 0; c < 3; c++) begin
            b0.req_valid = 1'b1;
            b0.req_addr  = AW'(1 + c);
            @(negedge clk);
            chk("t5_accept", 32'(b0.req_ready), 32'd1);
            step();
        end
        b0.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_resp_valid_in_rst", 32'(b0.resp_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t5_resp_valid_after_rst", 32'(b0.resp_valid), 32'd0);
            step();
        end
        single_read();

        // Test 6: BUF_DEPTH 3, resp_ready toggling, pointers wrap.
        na = 0;
        nresp1 = 0;
        for (int c = 0; c < 200 && na < 10; c++) begin
            b1.req_valid  = 1'b1;
            b1.req_addr   = AW'(10 + na);
            b1.resp_ready = c[0];
            @(negedge clk);
            if (b1.req_valid && b1.req_ready) na++;
            step();
        end
        chk("t6_accepts", 32'(na), 32'd10);
        b1.req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            b1.resp_ready = c[0];
            step();
        end
        b1.resp_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("t6_responses", 32'(nresp1), 32'd10);
        chk("t6_all_returned", 32'(q1.size()), 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
